// File: rtl/cpu_pkg.sv
// Shared opcode constants, the default idle instruction word and the fetch state encoding
// for the fetch unit and its next-PC logic.
package cpu_pkg;

    localparam logic [3:0]  BCOND     = 4'b1100;
    localparam logic [3:0]  JTYPE     = 4'b0100;
    localparam logic [3:0]  JCOND_EXT = 4'b1100;
    localparam logic [3:0]  JAL_EXT   = 4'b1000;
    localparam logic [15:0] NOP_WORD  = 16'h0020;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2
    } fetch_state_t;

    function automatic logic is_jal(input logic [15:0] decoded);
        return (decoded[15:12] == JTYPE) && (decoded[7:4] == JAL_EXT);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: relative branch, register jump or jump-and-link,
// otherwise sequential. All arithmetic wraps modulo 2^16.
module next_pc_calc #(
    parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic [15:0] pc,
    input  logic [15:0] decoded,
    input  logic [15:0] reg_data,
    output logic [15:0] next_pc
);
    import cpu_pkg::*;

    logic        w_is_branch;
    logic        w_is_jump;
    logic [15:0] w_disp;

    assign w_is_branch = (decoded[15:12] == BCOND) && (decoded != NOP_WORD);
    assign w_is_jump   = (decoded[15:12] == JTYPE) &&
                         ((decoded[7:4] == JCOND_EXT) || (decoded[7:4] == JAL_EXT));
    assign w_disp      = {{8{decoded[7]}}, decoded[7:0]};

    always_comb begin
        next_pc = pc + 16'd1;
        if (w_is_branch) begin
            next_pc = pc + w_disp;
        end else if (w_is_jump) begin
            next_pc = reg_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH -> DECODE -> EXECUTE, holding the instruction
// register for the external decoder and updating pc/retired on datapath completion.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_ren,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic [15:0] decoded,
    input  logic        ex_ready,
    output logic [3:0]  tgt_reg,
    input  logic [15:0] reg_data,
    output logic        link_we,
    output logic [3:0]  link_reg,
    output logic [15:0] link_data,
    output logic [15:0] pc,
    output logic [15:0] retired
);
    import cpu_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  r_instr;
    logic [15:0]  r_retired;
    logic [15:0]  w_next_pc;
    logic         w_mem_ren;
    logic         w_instr_valid;
    logic         w_link_we;
    logic         w_load_instr;
    logic         w_retire;

    next_pc_calc #(
        .NOP_WORD (NOP_WORD)
    ) u_next_pc (
        .pc       (r_pc),
        .decoded  (decoded),
        .reg_data (reg_data),
        .next_pc  (w_next_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH:   if (mem_valid) w_state_nxt = ST_DECODE;
            ST_DECODE:  w_state_nxt = ST_EXECUTE;
            ST_EXECUTE: if (ex_ready) w_state_nxt = ST_FETCH;
            default:    w_state_nxt = ST_FETCH;
        endcase
    end

    // mem_ren is masked by reset so no request is seen until reset releases
    always_comb begin
        w_mem_ren     = (r_state == ST_FETCH) && !reset;
        w_instr_valid = (r_state == ST_DECODE) || (r_state == ST_EXECUTE);
        w_load_instr  = (r_state == ST_FETCH) && mem_valid;
        w_retire      = (r_state == ST_EXECUTE) && ex_ready;
        w_link_we     = w_retire && is_jal(decoded);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr   <= NOP_WORD;
            r_retired <= 16'd0;
        end else begin
            if (w_load_instr) begin
                r_instr <= mem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign mem_addr    = r_pc;
    assign mem_ren     = w_mem_ren;
    assign instr       = r_instr;
    assign instr_valid = w_instr_valid;
    assign tgt_reg     = decoded[3:0];
    assign link_we     = w_link_we;
    assign link_reg    = decoded[11:8];
    assign link_data   = r_pc + 16'd1;
    assign pc          = r_pc;
    assign retired     = r_retired;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 16'h0020, meaning the instruction word held in instr while no fetched word is valid.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_addr, output, 16, the word address of the instruction being fetched.
REQ-006 SHALL have port mem_ren, output, 1, the fetch request.
REQ-007 SHALL have port mem_valid, input, 1, signalling that mem_rdata carries the requested word this cycle.
REQ-008 SHALL have port mem_rdata, input, 16, the fetched instruction word.
REQ-009 SHALL have port instr, output, 16, the instruction register driven to the flag-qualifying decoder.
REQ-010 SHALL have port instr_valid, output, 1, high while instr holds a fetched word.
REQ-011 SHALL have port decoded, input, 16, the flag-qualified instruction returned by the decoder.
REQ-012 SHALL have port ex_ready, input, 1, signalling that the datapath has completed the current instruction.
REQ-013 SHALL have port tgt_reg, output, 4, equal to decoded[3:0], the register-file read address for the jump target.
REQ-014 SHALL have port reg_data, input, 16, the register-file value at tgt_reg.
REQ-015 SHALL have port link_we, output, 1, a one-cycle pulse requesting a link write.
REQ-016 SHALL have port link_reg, output, 4, the link destination register, equal to decoded[11:8].
REQ-017 SHALL have port link_data, output, 16, the link value, pc+1.
REQ-018 SHALL have port pc, output, 16, the current program counter.
REQ-019 SHALL have port retired, output, 16, the count of retired instructions.

Function
REQ-020 SHALL implement the states FETCH, DECODE and EXECUTE.
REQ-021 In FETCH: mem_ren=1 and mem_addr=pc, held stable until mem_valid; on mem_valid, instr<=mem_rdata, then go to DECODE.
REQ-022 DECODE SHALL last exactly one cycle, to allow the decoder to settle, then go to EXECUTE; latency from mem_valid to the PC update is at least 2 cycles.
REQ-023 EXECUTE SHALL hold while ex_ready=0; on ex_ready=1: update pc, retired<=retired+1, then go to FETCH.
REQ-024 Branch (decoded[15:12]=4'b1100 and decoded!=NOP_WORD): pc <= pc + sign-extended decoded[7:0], modulo 2^16.
REQ-025 Jump (decoded[15:12]=4'b0100 and decoded[7:4]=4'b1100): pc <= reg_data.
REQ-026 Jump-and-link (decoded[15:12]=4'b0100 and decoded[7:4]=4'b1000): pc <= reg_data; link_we=1 for the ex_ready cycle, with link_data=pc+1.
REQ-027 Every other decoded value, including NOP_WORD (a suppressed conditional) and 16'h0080: pc <= pc+1.
REQ-028 pc+1 and branch arithmetic SHALL wrap 16'hFFFF -> 16'h0000; retired SHALL wrap 16'hFFFF -> 0.
REQ-029 instr_valid SHALL be 1 in DECODE and EXECUTE and 0 in FETCH; instr SHALL be NOP_WORD only after reset, before the first fetch completes.
REQ-030 A mem_valid received outside FETCH SHALL be ignored.
REQ-031 link_we SHALL be 0 in all cycles other than the one named in REQ-026.

Reset
REQ-032 While reset=1 (asynchronous): state=FETCH, pc=RESET_PC, instr=NOP_WORD, retired=0, link_we=0; mem_ren SHALL assert from the first clock after release.
REQ-033 A reset asserted mid-fetch or mid-EXECUTE SHALL abandon the operation with no PC update, no link write and no retire count.

Structure
REQ-034 A shared package cpu_pkg SHALL hold the opcode constants (BCOND 4'b1100, JTYPE 4'b0100, JCOND_EXT 4'b1100, JAL_EXT 4'b1000), NOP_WORD, and the fetch state enum.
REQ-035 Next-PC selection SHALL be one combinational sub-module, next_pc_calc (inputs pc, decoded, reg_data; output next pc).

Verification
REQ-036 Reset release with mem_valid after 3 cycles, rdata=16'h5123 -> mem_addr=0 held for 3 cycles; pc=1 after ex_ready; retired=1.
REQ-037 pc=16'h0010, decoded=16'hC0FE (taken, disp -2) -> pc=16'h000E; decoded=NOP_WORD -> pc=16'h0011.
REQ-038 pc=16'h0020, decoded=16'h40C7, reg_data=16'h1234 -> tgt_reg=7, pc=16'h1234, link_we=0.
REQ-039 pc=16'h0030, decoded=16'h4E83, reg_data=16'h0200 -> link_we pulse, link_reg=14, link_data=16'h0031, pc=16'h0200.
REQ-040 pc=16'hFFFF, sequential instruction -> pc=16'h0000; pc=16'h0000, branch disp 16'hFF -> pc=16'hFFFF.
REQ-041 ex_ready held low for 5 cycles then reset pulsed -> pc=RESET_PC, retired unchanged at 0, no link_we, FETCH re-entered.
